// File: rtl/sti_pkg.sv
// Shared definitions for the stack-bus upstream arbiter: control codes,
// FSM encoding and default widths.
package sti_pkg;

    localparam int STI_CNTL_W        = 2;
    localparam int STI_NUM_LANES_DEF = 4;
    localparam int STI_LANE_W_DEF    = 2;
    localparam int STI_DATA_W_DEF    = 64;
    localparam int STI_TYPE_W_DEF    = 2;

    localparam logic [1:0] STI_CNTL_SOP     = 2'b01;
    localparam logic [1:0] STI_CNTL_MOP     = 2'b10;
    localparam logic [1:0] STI_CNTL_EOP     = 2'b11;
    localparam logic [1:0] STI_CNTL_SOP_EOP = 2'b00;

    typedef enum logic {
        STI_IDLE  = 1'b0,
        STI_GRANT = 1'b1
    } sti_state_e;

    // Beat opens a packet (SOP or single-beat SOP_EOP).
    function automatic logic sti_is_start(input logic [1:0] cntl);
        return (cntl == STI_CNTL_SOP) || (cntl == STI_CNTL_SOP_EOP);
    endfunction

    // Beat closes a packet (EOP or single-beat SOP_EOP).
    function automatic logic sti_is_end(input logic [1:0] cntl);
        return (cntl == STI_CNTL_EOP) || (cntl == STI_CNTL_SOP_EOP);
    endfunction

endpackage

// File: rtl/sti_skid_buffer.sv
// Two-entry FIFO skid buffer; in_ready comes from a registered space flag so
// the downstream ready never reaches the upstream ready combinationally.
module sti_skid_buffer #(
    parameter int W = 70
) (
    input  logic         clk,
    input  logic         reset_poweron,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         space_q, space_d;
    logic         push_s, pop_s;

    // Next-state computation for storage, pointers, occupancy and space flag.
    always_comb begin
        push_s   = in_valid && space_q;
        pop_s    = (count_q != 2'd0) && out_ready;
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        space_d = (count_d != 2'd2);
    end

    // State registers with synchronous power-on reset.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            space_q  <= 1'b1;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            space_q  <= space_d;
        end
    end

    assign in_ready  = space_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sti_upstream_arbiter.sv
// Packet-atomic round-robin arbiter sharing the PE upstream stack-bus port
// among NUM_LANES streaming-op lanes, with a 2-entry output skid buffer.
module sti_upstream_arbiter
    import sti_pkg::*;
#(
    parameter int NUM_LANES = STI_NUM_LANES_DEF,
    parameter int LANE_W    = STI_LANE_W_DEF,
    parameter int DATA_W    = STI_DATA_W_DEF,
    parameter int TYPE_W    = STI_TYPE_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset_poweron,
    input  logic [NUM_LANES-1:0]        stOp__sti__valid,
    input  logic [2*NUM_LANES-1:0]      stOp__sti__cntl,
    input  logic [TYPE_W*NUM_LANES-1:0] stOp__sti__type,
    input  logic [DATA_W*NUM_LANES-1:0] stOp__sti__data,
    output logic [NUM_LANES-1:0]        sti__stOp__ready,
    output logic                        pe__stu__valid,
    output logic [1:0]                  pe__stu__cntl,
    output logic [TYPE_W-1:0]           pe__stu__type,
    output logic [DATA_W-1:0]           pe__stu__data,
    output logic [LANE_W-1:0]           pe__stu__lane,
    input  logic                        stu__pe__ready,
    output logic                        sti__cntl__proto_err
);

    localparam int PW = STI_CNTL_W + TYPE_W + DATA_W + LANE_W;

    sti_state_e       state_q, state_d;
    logic [LANE_W-1:0] grant_lane_q, grant_lane_d;
    logic [LANE_W-1:0] ptr_q, ptr_d;
    logic             err_q, err_d;
    logic             first_q, first_d;

    logic              found_s;
    int                scan_idx_s;
    logic [LANE_W-1:0] lane_idx_s;
    logic              lane_valid_s;
    logic [1:0]        lane_cntl_s;
    logic [TYPE_W-1:0] lane_type_s;
    logic [DATA_W-1:0] lane_data_s;
    logic              accept_s;
    logic              skid_space_s;
    logic [NUM_LANES-1:0] ready_s;
    logic [PW-1:0]     push_data_s;
    logic [PW-1:0]     skid_out_s;

    assign lane_valid_s = stOp__sti__valid[grant_lane_q];
    assign lane_cntl_s  = stOp__sti__cntl[grant_lane_q*STI_CNTL_W +: STI_CNTL_W];
    assign lane_type_s  = stOp__sti__type[grant_lane_q*TYPE_W +: TYPE_W];
    assign lane_data_s  = stOp__sti__data[grant_lane_q*DATA_W +: DATA_W];
    assign accept_s     = (state_q == STI_GRANT) && lane_valid_s && skid_space_s;
    assign push_data_s  = {lane_cntl_s, lane_type_s, lane_data_s, grant_lane_q};

    // Only the granted lane sees ready, and only while the skid has room.
    always_comb begin
        ready_s = '0;
        if (state_q == STI_GRANT) begin
            ready_s[grant_lane_q] = skid_space_s;
        end else begin
            ready_s = '0;
        end
    end

    // Arbitration FSM next-state: round-robin scan in IDLE, packet tracking in GRANT.
    always_comb begin
        state_d      = state_q;
        grant_lane_d = grant_lane_q;
        ptr_d        = ptr_q;
        err_d        = err_q;
        first_d      = first_q;
        found_s      = 1'b0;
        scan_idx_s   = 0;
        lane_idx_s   = '0;
        case (state_q)
            STI_IDLE: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    scan_idx_s = (int'(ptr_q) + i) % NUM_LANES;
                    lane_idx_s = LANE_W'(scan_idx_s);
                    if (!found_s && stOp__sti__valid[lane_idx_s]) begin
                        found_s      = 1'b1;
                        grant_lane_d = lane_idx_s;
                    end else begin
                        found_s = found_s;
                    end
                end
                if (found_s) begin
                    state_d = STI_GRANT;
                    first_d = 1'b1;
                end else begin
                    state_d = STI_IDLE;
                end
            end
            STI_GRANT: begin
                if (accept_s) begin
                    first_d = 1'b0;
                    // Malformed framing is flagged but the beat still goes out.
                    if (first_q && !sti_is_start(lane_cntl_s)) begin
                        err_d = 1'b1;
                    end else if (!first_q && sti_is_start(lane_cntl_s)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (sti_is_end(lane_cntl_s)) begin
                        ptr_d   = LANE_W'((int'(grant_lane_q) + 1) % NUM_LANES);
                        state_d = STI_IDLE;
                    end else begin
                        state_d = STI_GRANT;
                    end
                end else begin
                    state_d = STI_GRANT;
                end
            end
            default: begin
                state_d = STI_IDLE;
            end
        endcase
    end

    // Arbiter state registers with synchronous power-on reset.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q      <= STI_IDLE;
            grant_lane_q <= '0;
            ptr_q        <= '0;
            err_q        <= 1'b0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_lane_q <= grant_lane_d;
            ptr_q        <= ptr_d;
            err_q        <= err_d;
            first_q      <= first_d;
        end
    end

    sti_skid_buffer #(
        .W (PW)
    ) u_skid (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .in_valid      (accept_s),
        .in_ready      (skid_space_s),
        .in_data       (push_data_s),
        .out_valid     (pe__stu__valid),
        .out_ready     (stu__pe__ready),
        .out_data      (skid_out_s)
    );

    assign {pe__stu__cntl, pe__stu__type, pe__stu__data, pe__stu__lane} = skid_out_s;
    assign sti__stOp__ready     = ready_s;
    assign sti__cntl__proto_err = err_q;

endmodule

// File: tb/tb_sti_upstream_arbiter.sv
// Directed self-checking bench for sti_upstream_arbiter: lane sources are
// modelled as beat queues, upstream beats are collected and compared.
module tb_sti_upstream_arbiter;
    import sti_pkg::*;

    localparam int NL = 4;
    localparam int LW = 2;
    localparam int DW = 64;
    localparam int TW = 2;

    logic              clk = 1'b0;
    logic              reset_poweron;
    logic [NL-1:0]     valid;
    logic [2*NL-1:0]   cntl;
    logic [TW*NL-1:0]  typ;
    logic [DW*NL-1:0]  data;
    logic [NL-1:0]     ready;
    logic              pe_valid;
    logic [1:0]        pe_cntl;
    logic [TW-1:0]     pe_type;
    logic [DW-1:0]     pe_data;
    logic [LW-1:0]     pe_lane;
    logic              stu_ready;
    logic              proto_err;

    always #5 clk = ~clk;

    sti_upstream_arbiter dut (
        .clk                  (clk),
        .reset_poweron        (reset_poweron),
        .stOp__sti__valid     (valid),
        .stOp__sti__cntl      (cntl),
        .stOp__sti__type      (typ),
        .stOp__sti__data      (data),
        .sti__stOp__ready     (ready),
        .pe__stu__valid       (pe_valid),
        .pe__stu__cntl        (pe_cntl),
        .pe__stu__type        (pe_type),
        .pe__stu__data        (pe_data),
        .pe__stu__lane        (pe_lane),
        .stu__pe__ready       (stu_ready),
        .sti__cntl__proto_err (proto_err)
    );

    typedef struct packed {
        logic [1:0]  c;
        logic [63:0] d;
    } beat_t;

    typedef struct packed {
        logic [1:0]  lane;
        logic [1:0]  c;
        logic [1:0]  t;
        logic [63:0] d;
    } obeat_t;

    beat_t   lane_q [NL][$];
    obeat_t  out_q[$];
    logic [NL-1:0] acc_s;
    int      cyc;
    int      first_valid_cyc;
    logic    err_at_first;
    int      acc_cnt [NL];
    int      n_vec = 0;
    int      n_err = 0;

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic obeat_t get_out(input int i);
        obeat_t b;
        b = '1;
        if (i < out_q.size()) b = out_q[i];
        return b;
    endfunction

    task automatic drive_lanes();
        for (int l = 0; l < NL; l++) begin
            typ[l*TW +: TW] = TW'(l);
            if (lane_q[l].size() > 0) begin
                valid[l]        = 1'b1;
                cntl[l*2 +: 2]  = lane_q[l][0].c;
                data[l*DW +: DW] = lane_q[l][0].d;
            end else begin
                valid[l]        = 1'b0;
                cntl[l*2 +: 2]  = 2'b00;
                data[l*DW +: DW] = 64'd0;
            end
        end
    endtask

    task automatic add_beat(input int l, input logic [1:0] c, input logic [63:0] d);
        beat_t b;
        b.c = c;
        b.d = d;
        lane_q[l].push_back(b);
    endtask

    // One clock: sample at negedge, then advance lane sources after the posedge.
    task automatic step();
        obeat_t b;
        @(negedge clk);
        acc_s = valid & ready;
        if (pe_valid && first_valid_cyc < 0) begin
            first_valid_cyc = cyc;
            err_at_first    = proto_err;
        end
        if (pe_valid && stu_ready) begin
            b.lane = pe_lane;
            b.c    = pe_cntl;
            b.t    = pe_type;
            b.d    = pe_data;
            out_q.push_back(b);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int l = 0; l < NL; l++) begin
            if (acc_s[l] && lane_q[l].size() > 0) begin
                void'(lane_q[l].pop_front());
                acc_cnt[l]++;
            end
        end
        drive_lanes();
    endtask

    task automatic do_reset();
        for (int l = 0; l < NL; l++) begin
            lane_q[l].delete();
            acc_cnt[l] = 0;
        end
        out_q.delete();
        drive_lanes();
        stu_ready     = 1'b1;
        reset_poweron = 1'b1;
        @(posedge clk);
        #1;
        reset_poweron   = 1'b0;
        cyc             = 0;
        first_valid_cyc = -1;
        err_at_first    = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (out_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check_vec({tag, "_beats"}, 64'(out_q.size()), 64'(n));
    endtask

    initial begin
        obeat_t b;
        int bad;
        int cnt [NL];
        int kk [NL];

        valid = '0;
        cntl  = '0;
        typ   = '0;
        data  = '0;
        do_reset();

        // Reset state
        check_vec("rst_valid", 64'(pe_valid), 64'd0);
        check_vec("rst_ready", 64'(ready), 64'd0);
        check_vec("rst_err", 64'(proto_err), 64'd0);
        check_vec("rst_data", pe_data, 64'd0);
        check_vec("rst_lane", 64'(pe_lane), 64'd0);
        check_vec("rst_ptr", 64'(dut.ptr_q), 64'd0);

        // Single-beat packet from lane 2
        add_beat(2, STI_CNTL_SOP_EOP, 64'hA5);
        drive_lanes();
        run_until(1, 10, "t1");
        b = get_out(0);
        check_vec("t1_latency", 64'(first_valid_cyc), 64'd2);
        check_vec("t1_lane", 64'(b.lane), 64'd2);
        check_vec("t1_cntl", 64'(b.c), 64'(STI_CNTL_SOP_EOP));
        check_vec("t1_type", 64'(b.t), 64'd2);
        check_vec("t1_data", b.d, 64'hA5);
        check_vec("t1_ptr", 64'(dut.ptr_q), 64'd3);

        // Lanes 0 and 3 contend with 3-beat packets
        do_reset();
        for (int l = 0; l < NL; l += 3) begin
            add_beat(l, STI_CNTL_SOP, 64'(l * 16 + 0));
            add_beat(l, STI_CNTL_MOP, 64'(l * 16 + 1));
            add_beat(l, STI_CNTL_EOP, 64'(l * 16 + 2));
        end
        drive_lanes();
        run_until(6, 60, "t2");
        for (int i = 0; i < 6; i++) begin
            b = get_out(i);
            check_vec("t2_lane", 64'(b.lane), (i < 3) ? 64'd0 : 64'd3);
            check_vec("t2_data", b.d, (i < 3) ? 64'(i) : 64'(48 + i - 3));
            check_vec("t2_cntl", 64'(b.c), (i % 3 == 0) ? 64'(STI_CNTL_SOP) :
                                            (i % 3 == 1) ? 64'(STI_CNTL_MOP) : 64'(STI_CNTL_EOP));
        end
        check_vec("t2_ptr", 64'(dut.ptr_q), 64'd0);

        // Upstream stall during a 5-beat lane1 packet
        do_reset();
        stu_ready = 1'b0;
        add_beat(1, STI_CNTL_SOP, 64'h100);
        for (int i = 1; i < 4; i++) add_beat(1, STI_CNTL_MOP, 64'(256 + i));
        add_beat(1, STI_CNTL_EOP, 64'h104);
        drive_lanes();
        repeat (10) step();
        check_vec("t3_acc_stall", 64'(acc_cnt[1]), 64'd2);
        check_vec("t3_ready_low", 64'(ready[1]), 64'd0);
        check_vec("t3_hold_valid", 64'(pe_valid), 64'd1);
        check_vec("t3_hold_data", pe_data, 64'h100);
        stu_ready = 1'b1;
        run_until(5, 40, "t3");
        for (int i = 0; i < 5; i++) begin
            b = get_out(i);
            check_vec("t3_data", b.d, 64'(256 + i));
        end
        check_vec("t3_acc_total", 64'(acc_cnt[1]), 64'd5);

        // All lanes streaming single-beat packets
        do_reset();
        for (int l = 0; l < NL; l++) begin
            for (int k = 0; k < 20; k++) add_beat(l, STI_CNTL_SOP_EOP, 64'(l * 256 + k));
            cnt[l] = 0;
            kk[l]  = 0;
        end
        drive_lanes();
        repeat (40) step();
        bad = 0;
        for (int i = 0; i < out_q.size(); i++) begin
            b = out_q[i];
            if (int'(b.lane) != i % NL || b.d != 64'(int'(b.lane) * 256 + kk[b.lane])) bad++;
            cnt[b.lane]++;
            kk[b.lane]++;
        end
        check_vec("t4_rr_order", 64'(bad), 64'd0);
        for (int l = 0; l < NL; l++) begin
            check_vec("t4_lane_share", 64'(cnt[l] >= 4 && cnt[l] <= 6), 64'd1);
        end

        // Illegal first beat (MOP) sets sticky error
        do_reset();
        add_beat(0, STI_CNTL_MOP, 64'h55);
        add_beat(0, STI_CNTL_EOP, 64'h56);
        drive_lanes();
        run_until(2, 20, "t5");
        b = get_out(0);
        check_vec("t5_fwd_cntl", 64'(b.c), 64'(STI_CNTL_MOP));
        check_vec("t5_fwd_data", b.d, 64'h55);
        check_vec("t5_err_timing", 64'(err_at_first), 64'd1);
        add_beat(1, STI_CNTL_SOP_EOP, 64'h66);
        drive_lanes();
        run_until(3, 20, "t5b");
        check_vec("t5_err_sticky", 64'(proto_err), 64'd1);
        do_reset();
        check_vec("t5_err_cleared", 64'(proto_err), 64'd0);

        // Reset mid-packet discards it
        add_beat(1, STI_CNTL_SOP, 64'h10);
        add_beat(1, STI_CNTL_MOP, 64'h11);
        add_beat(1, STI_CNTL_EOP, 64'h12);
        drive_lanes();
        for (int k = 0; k < 10 && acc_cnt[1] < 2; k++) step();
        check_vec("t6_mop_taken", 64'(acc_cnt[1]), 64'd2);
        do_reset();
        check_vec("t6_valid", 64'(pe_valid), 64'd0);
        check_vec("t6_ready", 64'(ready), 64'd0);
        check_vec("t6_data", pe_data, 64'd0);
        check_vec("t6_cntl", 64'(pe_cntl), 64'd0);
        check_vec("t6_lane", 64'(pe_lane), 64'd0);
        check_vec("t6_state", 64'(dut.state_q), 64'd0);
        add_beat(1, STI_CNTL_SOP_EOP, 64'h77);
        drive_lanes();
        run_until(1, 10, "t6");
        b = get_out(0);
        check_vec("t6_new_lane", 64'(b.lane), 64'd1);
        check_vec("t6_new_data", b.d, 64'h77);
        check_vec("t6_new_cntl", 64'(b.c), 64'(STI_CNTL_SOP_EOP));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
